af_sweep_scheduler: RTL and testbench

//  Autofocus sequencer between the per-frame sharpness statistic and the VCM I2C writer.
//  On START it runs a coarse lens sweep, then a fine sweep around the coarse peak, then parks at the best step.
//  At every candidate position it issues one VCM write, waits for settling, and samples one frame score.

---
 rtl/af_sweep_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_af_sweep_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/af_sweep_scheduler.sv
// rtl/af_sweep_scheduler.sv - autofocus coarse/fine lens sweep sequencer driving the VCM writer
module af_sweep_scheduler #(
  parameter int STEP_W        = 10,
  parameter int SCORE_W       = 24,
  parameter int STEP_MAX      = 1023,
  parameter int COARSE_INC    = 32,
  parameter int FINE_INC      = 4,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic               video_clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               vs_ns_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic               score_vld_i,
  input  logic               i2c_busy_i,
  output logic [15:0]        vcm_data_o,
  output logic               vcm_wr_o,
  output logic [STEP_W-1:0]  step_o,
  output logic [STEP_W-1:0]  best_step_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic               busy_o,
  output logic               vcm_end_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_MOVE, S_WAIT_I2C, S_SETTLE, S_MEASURE, S_DECIDE, S_PARK, S_PARK_WAIT, S_DONE
  } state_t;

  // Step arithmetic is carried one bit wider so sums past STEP_MAX never wrap.
  localparam logic [STEP_W:0]  STEP_MAX_W   = (STEP_W+1)'(STEP_MAX);
  localparam logic [STEP_W:0]  COARSE_INC_W = (STEP_W+1)'(COARSE_INC);
  localparam logic [STEP_W:0]  FINE_INC_W   = (STEP_W+1)'(FINE_INC);
  localparam logic [2:0]       SETTLE_N     = 3'(SETTLE_FRAMES);
  // Writes are not acknowledged, so I2C_BUSY is blind for this many cycles after VCM_WR.
  localparam logic [1:0]       I2C_BLIND    = 2'd2;

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]    best_step_q, best_step_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [STEP_W-1:0]    phase_end_q, phase_end_d;
  logic                 fine_q, fine_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic [2:0]           settle_cnt_q, settle_cnt_d;
  logic                 vs_q;
  logic                 busy_q, busy_d;
  logic                 vcm_end_q, vcm_end_d;

  logic                 frame_start;
  logic                 better;
  logic [STEP_W-1:0]    best_step_new;
  logic [STEP_W:0]      next_w;
  logic [STEP_W:0]      best_w;
  logic [STEP_W:0]      win_hi_w;

  assign frame_start = vs_q & ~vs_ns_i;

  // State register and all sweep datapath registers.
  always_ff @(posedge video_clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      best_step_q  <= '0;
      best_score_q <= '0;
      score_q      <= '0;
      phase_end_q  <= '0;
      fine_q       <= 1'b0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      vs_q         <= 1'b1;
      busy_q       <= 1'b0;
      vcm_end_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      best_step_q  <= best_step_d;
      best_score_q <= best_score_d;
      score_q      <= score_d;
      phase_end_q  <= phase_end_d;
      fine_q       <= fine_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      vs_q         <= vs_ns_i;
      busy_q       <= busy_d;
      vcm_end_q    <= vcm_end_d;
    end
  end

  // Next-state and datapath update: sequencing, score comparison and window computation.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    best_step_d  = best_step_q;
    best_score_d = best_score_q;
    score_d      = score_q;
    phase_end_d  = phase_end_q;
    fine_d       = fine_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    busy_d       = busy_q;
    vcm_end_d    = vcm_end_q;

    // Strict compare: on a tie the earlier visited step keeps the crown.
    better        = score_q > best_score_q;
    best_step_new = better ? step_q : best_step_q;
    next_w        = {1'b0, step_q} + (fine_q ? FINE_INC_W : COARSE_INC_W);
    best_w        = {1'b0, best_step_new};
    win_hi_w      = best_w + COARSE_INC_W;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d       = 1'b1;
          vcm_end_d    = 1'b0;
          best_score_d = '0;
          best_step_d  = '0;
          step_d       = '0;
          fine_d       = 1'b0;
          phase_end_d  = STEP_MAX_W[STEP_W-1:0];
          state_d      = S_MOVE;
        end
      end
      S_MOVE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_I2C;
      end
      S_WAIT_I2C: begin
        if (wait_cnt_q != I2C_BLIND) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else if (!i2c_busy_i) begin
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // A score strobe here belongs to a frame taken while the lens was moving.
        if (frame_start) begin
          settle_cnt_d = settle_cnt_q + 3'd1;
          if (settle_cnt_q + 3'd1 == SETTLE_N) begin
            state_d = S_MEASURE;
          end
        end
      end
      S_MEASURE: begin
        if (score_vld_i) begin
          score_d = score_i;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (better) begin
          best_score_d = score_q;
          best_step_d  = step_q;
        end
        if (step_q == phase_end_q) begin
          if (!fine_q) begin
            step_d      = (best_w >= COARSE_INC_W) ? best_step_new - COARSE_INC_W[STEP_W-1:0] : '0;
            phase_end_d = (win_hi_w > STEP_MAX_W) ? STEP_MAX_W[STEP_W-1:0] : win_hi_w[STEP_W-1:0];
            fine_d      = 1'b1;
            state_d     = S_MOVE;
          end else begin
            step_d  = best_step_new;
            state_d = S_PARK;
          end
        end else if (next_w > {1'b0, phase_end_q}) begin
          step_d  = phase_end_q;
          state_d = S_MOVE;
        end else begin
          step_d  = next_w[STEP_W-1:0];
          state_d = S_MOVE;
        end
      end
      S_PARK: begin
        wait_cnt_d = '0;
        state_d    = S_PARK_WAIT;
      end
      S_PARK_WAIT: begin
        if (wait_cnt_q != I2C_BLIND) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else if (!i2c_busy_i) begin
          busy_d    = 1'b0;
          vcm_end_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: write strobe in the two write states; VCM data follows STEP, which only changes on entry to them.
  always_comb begin
    vcm_wr_o     = (state_q == S_MOVE) || (state_q == S_PARK);
    vcm_data_o   = 16'({step_q, 4'b0000});
    step_o       = step_q;
    best_step_o  = best_step_q;
    best_score_o = best_score_q;
    busy_o       = busy_q;
    vcm_end_o    = vcm_end_q;
  end

endmodule

// File: tb/tb_af_sweep_scheduler.sv
// tb/tb_af_sweep_scheduler.sv - scoreboard bench for af_sweep_scheduler with camera and I2C models
module tb_af_sweep_scheduler;

  localparam int FRAME = 16;
  localparam int BUDGET = 25000;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        vs_ns_i = 1'b1;
  logic [23:0] score_i = '0;
  logic        score_vld_i = 1'b0;
  logic        i2c_busy_i = 1'b0;
  logic [15:0] vcm_data_o;
  logic        vcm_wr_o;
  logic [9:0]  step_o;
  logic [9:0]  best_step_o;
  logic [23:0] best_score_o;
  logic        busy_o;
  logic        vcm_end_o;

  af_sweep_scheduler dut (
    .video_clk_i (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .vs_ns_i     (vs_ns_i),
    .score_i     (score_i),
    .score_vld_i (score_vld_i),
    .i2c_busy_i  (i2c_busy_i),
    .vcm_data_o  (vcm_data_o),
    .vcm_wr_o    (vcm_wr_o),
    .step_o      (step_o),
    .best_step_o (best_step_o),
    .best_score_o(best_score_o),
    .busy_o      (busy_o),
    .vcm_end_o   (vcm_end_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  st;
    logic [23:0] sc;
  } res_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_count = 0;
  logic [15:0] exp_wr_q[$];
  res_t        exp_res_q[$];

  // scene / lens / camera model state
  bit          flat_scene = 1'b0;
  int          peak = 500;
  int          busy_len = 3;
  bit          stray_en = 1'b0;
  logic [9:0]  lens_pos = '0;
  logic [9:0]  cap_cur = '0;
  logic [9:0]  cap_prev = '0;
  int          fc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] lens_score(input logic [9:0] s);
    int d;
    if (flat_scene) return 24'd5000;
    d = (int'(s) > peak) ? int'(s) - peak : peak - int'(s);
    return 24'(100000 - d * 10);
  endfunction

  // camera: frame start at fc==0, score of the previous frame at fc==8
  initial begin
    forever begin
      @(negedge clk);
      score_vld_i = 1'b0;
      if (fc == 0) begin
        vs_ns_i  = 1'b0;
        cap_prev = cap_cur;
        cap_cur  = lens_pos;
        if (stray_en) begin
          score_vld_i = 1'b1;
          score_i     = 24'hFFFFFF;
        end
      end else if (fc == 2) begin
        vs_ns_i = 1'b1;
      end else if (fc == 8) begin
        score_vld_i = 1'b1;
        score_i     = lens_score(cap_prev);
      end
      fc = (fc == FRAME - 1) ? 0 : fc + 1;
    end
  end

  // I2C writer: busy for busy_len cycles, lens reaches the new code when busy drops
  initial begin
    logic [9:0] pend;
    forever begin
      @(negedge clk);
      if (vcm_wr_o && !reset_i) begin
        pend       = vcm_data_o[13:4];
        i2c_busy_i = 1'b1;
        repeat (busy_len) @(negedge clk);
        i2c_busy_i = 1'b0;
        lens_pos   = pend;
      end
    end
  end

  // monitor: every VCM write and every completion is matched against the scoreboard
  initial begin
    logic        end_prev;
    logic [15:0] e;
    res_t        r;
    end_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (vcm_wr_o) begin
        wr_count++;
        if (exp_wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL vcm_wr_unexpected: got data %h expected no write", vcm_data_o);
        end else begin
          e = exp_wr_q.pop_front();
          check("vcm_data", {16'h0, vcm_data_o}, {16'h0, e});
        end
      end
      if (vcm_end_o && !end_prev) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL vcm_end_unexpected: got vcm_end 1 expected 0");
        end else begin
          r = exp_res_q.pop_front();
          check("best_step", {22'h0, best_step_o}, {22'h0, r.st});
          check("best_score", {8'h0, best_score_o}, {8'h0, r.sc});
          check("park_step", {22'h0, step_o}, {22'h0, r.st});
          check("busy_at_done", {31'h0, busy_o}, 32'd0);
        end
      end
      end_prev = vcm_end_o;
    end
  end

  task automatic push_range(input int lo, input int hi, input int inc);
    int s;
    s = lo;
    forever begin
      exp_wr_q.push_back(16'(s << 4));
      if (s == hi) break;
      s = s + inc;
      if (s > hi) s = hi;
    end
  endtask

  task automatic push_sweep(input int flo, input int fhi, input int park, input int sc);
    res_t r;
    push_range(0, 1023, 32);
    push_range(flo, fhi, 4);
    exp_wr_q.push_back(16'(park << 4));
    r.st = 10'(park);
    r.sc = 24'(sc);
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base, input int writes);
    int cyc;
    cyc = 0;
    while (!vcm_end_o && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (!vcm_end_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no vcm_end after %0d cycles expected completion", name, cyc);
    end
    repeat (2) @(negedge clk);
    check({name, "_writes"}, wr_count - base, writes);
    check({name, "_leftover"}, exp_wr_q.size(), 0);
    exp_wr_q.delete();
    exp_res_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, {16'h0, vcm_data_o}, 32'd0);
    check({name, "_wr"}, {31'h0, vcm_wr_o}, 32'd0);
    check({name, "_step"}, {22'h0, step_o}, 32'd0);
    check({name, "_best_step"}, {22'h0, best_step_o}, 32'd0);
    check({name, "_best_score"}, {8'h0, best_score_o}, 32'd0);
    check({name, "_busy"}, {31'h0, busy_o}, 32'd0);
    check({name, "_end"}, {31'h0, vcm_end_o}, 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    int fs_seen;
    logic vs_prev;

    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // peak at 500: coarse best 512, fine 480..544, park 500
    flat_scene = 1'b0; peak = 500;
    push_sweep(480, 544, 500, 100000);
    base = wr_count;
    pulse_start();
    check("start_busy", {31'h0, busy_o}, 32'd1);
    wait_done("peak500", base, 51);
    check("peak500_vcm_data", {16'h0, vcm_data_o}, 32'h1F40);
    check("peak500_vcm_end", {31'h0, vcm_end_o}, 32'd1);

    // peak at 0: window clamps at 0
    peak = 0;
    push_sweep(0, 32, 0, 100000);
    base = wr_count;
    pulse_start();
    wait_done("peak0", base, 43);

    // peak at 1023: window 991..1023, 1023 visited once per phase
    peak = 1023;
    push_sweep(991, 1023, 1023, 100000);
    base = wr_count;
    pulse_start();
    wait_done("peak1023", base, 43);

    // flat scene: ties keep step 0
    flat_scene = 1'b1;
    push_sweep(0, 32, 0, 5000);
    base = wr_count;
    pulse_start();
    wait_done("flat", base, 43);

    // slow I2C and stray score strobes at every frame start
    flat_scene = 1'b0; peak = 500; busy_len = 300; stray_en = 1'b1;
    push_sweep(480, 544, 500, 100000);
    base = wr_count;
    pulse_start();
    wait_done("slow_i2c", base, 51);
    busy_len = 3; stray_en = 1'b0;

    // reset in the 10th coarse MEASURE
    push_sweep(480, 544, 500, 100000);
    base = wr_count;
    pulse_start();
    cyc = 0;
    while (wr_count < base + 10 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    while (!i2c_busy_i && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    while (i2c_busy_i && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    fs_seen = 0;
    vs_prev = vs_ns_i;
    while (fs_seen < 2 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (vs_prev && !vs_ns_i) fs_seen++;
      vs_prev = vs_ns_i;
    end
    if (cyc >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reset_setup_timeout: got %0d writes expected at least %0d", wr_count - base, 10);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    exp_wr_q.delete();
    exp_res_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // restart one cycle after release; a second START mid-sweep is ignored
    peak = 0;
    push_sweep(0, 32, 0, 100000);
    base = wr_count;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("restart_busy", {31'h0, busy_o}, 32'd1);
    repeat (300) @(negedge clk);
    pulse_start();
    wait_done("restart", base, 43);

    // START after DONE clears VCM_END and begins a new sweep
    flat_scene = 1'b1;
    push_sweep(0, 32, 0, 5000);
    base = wr_count;
    check("end_before_restart", {31'h0, vcm_end_o}, 32'd1);
    pulse_start();
    check("end_fall", {31'h0, vcm_end_o}, 32'd0);
    check("rebusy", {31'h0, busy_o}, 32'd1);
    wait_done("again", base, 43);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
